// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, FSM states
// and the operand magnitude helper used when latching signed divides.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  localparam int DIV_STEPS = 32;

  // Absolute value for signed operands; raw value for unsigned ones.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    logic [31:0] r;
    if (is_signed && v[31]) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_step_unit.sv
// One restoring division step: shift remainder:quotient left by one,
// trial-subtract the divisor and shift in the resulting quotient bit.
module div_step_unit (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted_s;
  logic [32:0] diff_s;

  // The remainder is always below the divisor, so the trial result fits in 33 bits.
  always_comb begin
    shifted_s = {rem_i, quo_i[31]};
    diff_s    = shifted_s - {1'b0, dvs_i};
    if (!diff_s[32]) begin
      rem_o = diff_s[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = shifted_s[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide controller owning the architectural HI/LO
// registers; stalls the pipeline while an operation is in flight.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int XLEN       = 32
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_value,
  input  logic [XLEN-1:0] rt_value,
  input  logic            hilo_rd,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            done,
  output logic            div_zero
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_LAST = 6'(DIV_STEPS - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d, dz_q, dz_d;
  logic [63:0] ma_q, ma_d, mb_q, mb_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic        negq_q, negq_d, negr_q, negr_d;

  logic        is_mul_s, is_div_s, rt_zero_s, busy_s;
  logic [63:0] prod_s;
  logic [31:0] step_rem_s, step_quo_s;

  assign is_mul_s  = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_s  = (op == OP_DIV) || (op == OP_DIVU);
  assign rt_zero_s = (rt_value == 32'd0);
  assign busy_s    = (state_q != S_IDLE);
  // Operands are stored sign- or zero-extended, so the low 64 bits of a plain product suffice.
  assign prod_s    = ma_q * mb_q;

  assign stall = busy_s
               | (start & (is_mul_s | (is_div_s & ~rt_zero_s)))
               | (hilo_rd & busy_s);

  div_step_unit u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem_s),
    .quo_o (step_quo_s)
  );

  // Next-state and datapath update; flush overrides everything, including a new start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    ma_d    = ma_q;
    mb_d    = mb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hi_d = rs_value;
              OP_MTLO: lo_d = rs_value;
              OP_MULT, OP_MULTU: begin
                ma_d    = {{32{(op == OP_MULT) && rs_value[31]}}, rs_value};
                mb_d    = {{32{(op == OP_MULT) && rt_value[31]}}, rt_value};
                state_d = S_MUL;
                cnt_d   = 6'd1;
              end
              OP_DIV, OP_DIVU: begin
                if (rt_zero_s) begin
                  done_d = 1'b1;
                  dz_d   = 1'b1;
                end else begin
                  rem_d   = 32'd0;
                  quo_d   = magnitude(rs_value, op == OP_DIV);
                  dvs_d   = magnitude(rt_value, op == OP_DIV);
                  negq_d  = (op == OP_DIV) && (rs_value[31] ^ rt_value[31]);
                  negr_d  = (op == OP_DIV) && rs_value[31];
                  state_d = S_DIV;
                  cnt_d   = 6'd0;
                end
              end
              default: state_d = S_IDLE;
            endcase
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL: begin
          if (cnt_q == MUL_LAST) begin
            {hi_d, lo_d} = prod_s;
            done_d       = 1'b1;
            state_d      = S_IDLE;
            cnt_d        = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        S_DIV: begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          if (cnt_q == DIV_LAST) begin
            state_d = S_FIX;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        S_FIX: begin
          lo_d    = negq_q ? (32'd0 - quo_q) : quo_q;
          hi_d    = negr_q ? (32'd0 - rem_q) : rem_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ma_q    <= 64'd0;
      mb_q    <= 64'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed and random mul/div traffic
// compared against an arithmetic HI/LO reference model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int MC = 2;
  localparam int DIV_LAT = 34;

  logic        clock = 1'b0;
  logic        resetn, start, hilo_rd, flush;
  logic [2:0]  op;
  logic [31:0] rs_value, rt_value;
  logic        stall, done, div_zero;
  logic [31:0] hi, lo;

  int          total = 0;
  int          bad = 0;
  logic [31:0] ref_hi, ref_lo;

  always #5 clock = ~clock;

  muldiv_ctrl #(.MUL_CYCLES(MC), .XLEN(32)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .op       (op),
    .rs_value (rs_value),
    .rt_value (rt_value),
    .hilo_rd  (hilo_rd),
    .flush    (flush),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo),
    .done     (done),
    .div_zero (div_zero)
  );

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference result {hi,lo} from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  p = sa * sb;
      OP_MULTU: p = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
      end
      OP_DIVU:  p = {a % b, a / b};
      default:  p = {ref_hi, ref_lo};
    endcase
    return p;
  endfunction

  // Hold start until done (as EX does while stalled); report latency and unstalled cycles.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int gaps);
    op = o; rs_value = a; rt_value = b; start = 1'b1;
    lat = -1; gaps = 0;
    for (int c = 1; c <= 60; c++) begin
      #1;
      if (stall !== 1'b1) gaps++;
      tick();
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    #1;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    op = o; rs_value = v; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    #1;
    ref_hi = 32'd0; ref_lo = 32'd0;
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
    total++; if (done !== 1'b0 || div_zero !== 1'b0) begin bad++; $display("FAIL reset_flags: got done=%b dz=%b want 0", done, div_zero); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
  endtask

  task automatic test_mul();
    logic [2:0] o; logic [31:0] a, b; logic [63:0] e; int lat, gaps;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin o = OP_MULT; a = 32'hFFFF_FFFD; b = 32'd5; end
      else if (i == 1) begin o = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'd2; end
      else begin o = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU; a = $urandom; b = $urandom; end
      e = ref_result(o, a, b);
      do_op(o, a, b, lat, gaps);
      ref_hi = e[63:32]; ref_lo = e[31:0];
      total++; if (lat != MC + 1) begin bad++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, MC + 1); end
      total++; if (gaps != 0) begin bad++; $display("FAIL mul_stall[%0d]: got %0d unstalled cycles want 0", i, gaps); end
      total++; if (hi !== ref_hi || lo !== ref_lo) begin bad++; $display("FAIL mul_result[%0d]: got %h_%h want %h_%h", i, hi, lo, ref_hi, ref_lo); end
      total++; if (div_zero !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mul_flags[%0d]: got dz=%b stall=%b want 0 0", i, div_zero, stall); end
    end
  endtask

  task automatic test_div();
    logic [2:0] o; logic [31:0] a, b; logic [63:0] e; int lat, gaps;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin o = OP_DIV; a = 32'hFFFF_FFF9; b = 32'd2; end
      else if (i == 1) begin o = OP_DIVU; a = 32'd100; b = 32'd7; end
      else if (i == 2) begin o = OP_DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else begin
        o = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
        a = $urandom;
        b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300));
        if (b == 32'd0) b = 32'd3;
      end
      e = ref_result(o, a, b);
      do_op(o, a, b, lat, gaps);
      ref_hi = e[63:32]; ref_lo = e[31:0];
      total++; if (lat != DIV_LAT) begin bad++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, DIV_LAT); end
      total++; if (gaps != 0) begin bad++; $display("FAIL div_stall[%0d]: got %0d unstalled cycles want 0", i, gaps); end
      total++; if (hi !== ref_hi || lo !== ref_lo) begin bad++; $display("FAIL div_result[%0d]: got %h_%h want %h_%h", i, hi, lo, ref_hi, ref_lo); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL div_dz[%0d]: got %b want 0", i, div_zero); end
    end
  endtask

  task automatic test_div_zero();
    int lat, gaps;
    mt(OP_MTHI, 32'h11); ref_hi = 32'h11;
    mt(OP_MTLO, 32'h22); ref_lo = 32'h22;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mt_no_done: got %b want 0", done); end
    for (int i = 0; i < 2; i++) begin
      do_op((i == 0) ? OP_DIV : OP_DIVU, $urandom, 32'd0, lat, gaps);
      total++; if (lat != 1) begin bad++; $display("FAIL dz_latency[%0d]: got %0d want 1", i, lat); end
      total++; if (gaps != 1) begin bad++; $display("FAIL dz_stall[%0d]: got %0d unstalled cycles want 1", i, gaps); end
      total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag[%0d]: got %b want 1", i, div_zero); end
      total++; if (hi !== ref_hi || lo !== ref_lo) begin bad++; $display("FAIL dz_hilo[%0d]: got %h_%h want %h_%h", i, hi, lo, ref_hi, ref_lo); end
      tick();
      total++; if (done !== 1'b0 || div_zero !== 1'b0) begin bad++; $display("FAIL dz_pulse[%0d]: got done=%b dz=%b want 0 0", i, done, div_zero); end
    end
  endtask

  task automatic test_flush();
    int pulses;
    op = OP_DIVU; rs_value = 32'd100; rt_value = 32'd7; start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_pre_stall[%0d]: got %b want 1", c, stall); end
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0; start = 1'b0;
    #1;
    total++; if (stall !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL flush_idle: got stall=%b done=%b want 0 0", stall, done); end
    total++; if (hi !== ref_hi || lo !== ref_lo) begin bad++; $display("FAIL flush_hilo: got %h_%h want %h_%h", hi, lo, ref_hi, ref_lo); end
    tick();
    mt(OP_MTLO, 32'h5); ref_lo = 32'h5;
    total++; if (lo !== 32'h5 || hi !== ref_hi) begin bad++; $display("FAIL flush_mtlo: got %h_%h want %h_%h", hi, lo, ref_hi, ref_lo); end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin tick(); if (done === 1'b1) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL flush_no_done: got %0d pulses want 0", pulses); end
    // flush together with start: nothing accepted
    op = OP_MTHI; rs_value = 32'hDEAD; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    total++; if (hi !== ref_hi) begin bad++; $display("FAIL flush_start_mthi: got %h want %h", hi, ref_hi); end
    op = OP_MULT; rs_value = 32'd9; rt_value = 32'd9; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_start_mul_stall: got %b want 0", stall); end
    pulses = 0;
    for (int c = 0; c < 6; c++) begin tick(); if (done === 1'b1) pulses++; end
    total++; if (pulses != 0 || hi !== ref_hi || lo !== ref_lo) begin bad++; $display("FAIL flush_start_mul: got pulses=%0d %h_%h want 0 %h_%h", pulses, hi, lo, ref_hi, ref_lo); end
  endtask

  task automatic test_hilo_rd();
    logic [63:0] e; int lat, gaps;
    mt(OP_MTHI, 32'hABCD); ref_hi = 32'hABCD;
    total++; if (hi !== 32'hABCD) begin bad++; $display("FAIL mthi: got %h want 0000abcd", hi); end
    hilo_rd = 1'b1;
    e = ref_result(OP_MULT, 32'h1234, 32'hFFFF_0000);
    do_op(OP_MULT, 32'h1234, 32'hFFFF_0000, lat, gaps);
    ref_hi = e[63:32]; ref_lo = e[31:0];
    total++; if (gaps != 0 || lat != MC + 1) begin bad++; $display("FAIL hilo_rd_stall: got gaps=%0d lat=%0d want 0 %0d", gaps, lat, MC + 1); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL hilo_rd_release: got %b want 0", stall); end
    total++; if (hi !== ref_hi || lo !== ref_lo) begin bad++; $display("FAIL hilo_rd_result: got %h_%h want %h_%h", hi, lo, ref_hi, ref_lo); end
    hilo_rd = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, gaps;
    op = OP_DIV; rs_value = 32'h0001_2345; rt_value = 32'h77; start = 1'b1;
    repeat (21) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1; start = 1'b0;
    #1;
    ref_hi = 32'd0; ref_lo = 32'd0;
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL rst_mid_hilo: got %h_%h want 0_0", hi, lo); end
    total++; if (stall !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_flags: got stall=%b done=%b want 0 0", stall, done); end
    do_op(OP_DIVU, 32'd100, 32'd7, lat, gaps);
    total++; if (lat != DIV_LAT || lo !== 32'd14 || hi !== 32'd2) begin bad++; $display("FAIL rst_mid_after: got lat=%0d %h_%h want %0d 00000002_0000000e", lat, hi, lo, DIV_LAT); end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; op = 3'd0; rs_value = 32'd0; rt_value = 32'd0;
    hilo_rd = 1'b0; flush = 1'b0;
    ref_hi = 32'd0; ref_lo = 32'd0;
    @(negedge clock);
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_hilo_rd();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide unit with a controller. It owns the architectural HI/LO registers for the MIPS EX stage.
- Accepts mult/multu/div/divu/mthi/mtlo from EX and sequences an iterative radix-2 divider and a fixed-latency multiplier.
- Raises a pipeline stall while busy and reports divide-by-zero.
- Replaces the combinational HI/LO logic in EX. EX reads hi/lo for mfhi/mflo.

Parameters:
MUL_CYCLES, 2, cycles spent in MUL state before the product is written (1..8)
XLEN, 32, operand width (only 32 is supported)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  synchronous active-low reset
start  in  1  EX presents a valid HI/LO-class instruction this cycle
op  in  3  operation code, from the shared package
rs_value  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
rt_value  in  32  forwarded rt operand (divisor / multiplier)
hilo_rd  in  1  EX holds an mfhi/mflo this cycle
flush  in  1  kill any in-flight operation (exception/redirect)
stall  out  1  hold IF/ID/EX
hi  out  32  HI register
lo  out  32  LO register
done  out  1  one-cycle pulse when a mul/div commits or faults
div_zero  out  1  one-cycle pulse together with done when the divisor is 0

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE; hi=0; lo=0; done=0; div_zero=0; counter=0. Reset mid-operation abandons the operation immediately.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + start + MTHI/MTLO:
  - hi (or lo) <= rs_value at this edge.
  - Stays in IDLE; no stall; no done.
- IDLE + start + MULT/MULTU:
  - Latch operands; product = signed or unsigned 64-bit.
  - Go to MUL with cnt=1.
  - MUL: cnt increments each cycle. When cnt==MUL_CYCLES, {hi,lo} <= product and go to IDLE.
  - For start at cycle T, new hi/lo are visible and done=1 in cycle T+MUL_CYCLES+1.
- IDLE + start + DIV/DIVU with rt_value==0:
  - Stays in IDLE; hi/lo unchanged.
  - done=1 and div_zero=1 in cycle T+1.
- IDLE + start + DIV/DIVU with rt_value!=0:
  - Latch |rs|, |rt| (raw values for DIVU) and the two sign bits. Go to DIV with cnt=0.
  - DIV: one restoring step per cycle (shift remainder:quotient, trial subtract, set quotient bit). After 32 steps go to FIX.
  - FIX:
    - quotient negated if signs differ (DIV only);
    - remainder negated if dividend negative (DIV only);
    - lo <= quotient, hi <= remainder; go to IDLE.
  - Results are visible and done=1 in cycle T+34.
- stall is combinational:
  - stall = (state!=IDLE) | (start & op in {MULT,MULTU,DIV,DIVU} & rt-nonzero-or-mul) | (hilo_rd & state!=IDLE).
  - Divide-by-zero never stalls.
  - EX keeps start/op/operands stable while stalled. start is ignored outside IDLE.
- flush:
  - Any state goes to IDLE at the next edge; hi/lo unchanged; no done.
  - flush and start in the same cycle: flush wins and nothing is accepted.
- Signed edge case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- done and div_zero are registered and low in every other cycle.

Decomposition:
- Package muldiv_pkg:
  - op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5;
  - state enum;
  - constant DIV_STEPS=32.
- Sub-module div_step_unit: one combinational restoring step (remainder, quotient, divisor in; next remainder, quotient out). The controller holds the FSM, counter, sign fix-up and HI/LO.

Test Plan:
1. MULT rs=0xFFFFFFFD rt=5 at T (MUL_CYCLES=2) -> stall in T..T+2; at T+3 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU rs=0xFFFFFFFF rt=2 -> hi=0x00000001, lo=0xFFFFFFFE.
2. DIV rs=0xFFFFFFF9 (-7) rt=2 at T -> stall for 34 cycles; at T+34 done=1, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
3. DIV rt=0 with prior hi=0x11, lo=0x22 -> no stall; at T+1 done=1, div_zero=1; hi=0x11, lo=0x22 unchanged.
4. DIV 100/7 started at T, flush at T+10 -> T+11 state IDLE, stall=0, done never pulses, hi/lo unchanged; a new MTLO 0x5 at T+12 -> lo=5 at T+13.
5. MTHI 0xABCD then hilo_rd during an in-flight MULT -> hi=0xABCD next cycle; stall held until the MULT done cycle. Flush+start in the same cycle -> nothing accepted.
6. resetn=0 during DIV step 20 -> next cycle hi=lo=0, state IDLE, stall=0, done=0.
